// File: rtl/gb_cart_pkg.sv
// ============================================================================
// Module  : gb_cart_pkg
// Brief   : Shared cartridge region decode constants and request FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gb_cart_pkg;

  localparam logic [1:0] c_RGN_NONE = 2'd0;
  localparam logic [1:0] c_RGN_ROM0 = 2'd1;
  localparam logic [1:0] c_RGN_ROMX = 2'd2;
  localparam logic [1:0] c_RGN_CRAM = 2'd3;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  function automatic logic [1:0] region_of(input logic [15:0] addr);
    if (addr[15:14] == 2'b00)
      return c_RGN_ROM0;
    else if (addr[15:14] == 2'b01)
      return c_RGN_ROMX;
    else if (addr[15:13] == 3'b101)
      return c_RGN_CRAM;
    else
      return c_RGN_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cart_mbc1_if.sv
// ============================================================================
// Module  : cart_mbc1_if
// Brief   : Console-side cartridge bus plus backing-memory request bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cart_mbc1_if #(
  parameter int ROM_AW = 21
) ();
  logic [15:0]       cart_addr;
  logic              cart_rd;
  logic              cart_wr;
  logic [7:0]        cart_di;
  logic [7:0]        cart_do;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ram;
  logic [ROM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cart_addr, cart_rd, cart_wr, cart_di, mem_rdata, mem_ack,
    output cart_do, mem_req, mem_we, mem_ram, mem_addr, mem_wdata
  );

  modport master (
    output cart_addr, cart_rd, cart_wr, cart_di, mem_rdata, mem_ack,
    input  cart_do, mem_req, mem_we, mem_ram, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mbc1_regs.sv
// ============================================================================
// Module  : mbc1_regs
// Brief   : MBC1 bank register file and console-to-backing address mapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mbc1_regs
  import gb_cart_pkg::*;
#(
  parameter int ROM_AW = 21,
  parameter int RAM_AW = 15
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  input  wire logic              i_wr_evt,
  input  wire logic [15:0]       i_addr,
  input  wire logic [4:0]        i_di,
  output logic                   o_ram_en,
  output logic [ROM_AW-1:0]      o_map_addr
);

  logic        r_ram_en;
  logic [4:0]  r_bank1;
  logic [1:0]  r_bank2;
  logic        r_mode;
  logic [1:0]  w_rgn;
  logic [1:0]  w_hi;
  logic [4:0]  w_eff;
  logic [20:0] w_rom_full;
  logic [14:0] w_ram_full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ram_en <= 1'b0;
      r_bank1  <= 5'd0;
      r_bank2  <= 2'd0;
      r_mode   <= 1'b0;
    end else if (i_wr_evt && !i_addr[15]) begin
      case (i_addr[14:13])
        2'b00:   r_ram_en <= (i_di[3:0] == 4'hA);
        2'b01:   r_bank1  <= i_di[4:0];
        2'b10:   r_bank2  <= i_di[1:0];
        default: r_mode   <= i_di[0];
      endcase
    end
  end

  // Bank 0 in the low register is unreachable through 4000-7FFF; it aliases to 1.
  assign w_eff    = (r_bank1 == 5'd0) ? 5'd1 : r_bank1;
  assign w_hi     = r_mode ? r_bank2 : 2'b00;
  assign w_rgn    = region_of(i_addr);
  assign o_ram_en = r_ram_en;

  always_comb begin
    w_rom_full = (w_rgn == c_RGN_ROMX) ? {r_bank2, w_eff, i_addr[13:0]}
                                       : {w_hi, 5'b00000, i_addr[13:0]};
    w_ram_full = {w_hi, i_addr[12:0]};
    o_map_addr = '0;
    if (w_rgn == c_RGN_CRAM)
      o_map_addr[RAM_AW-1:0] = w_ram_full[RAM_AW-1:0];
    else
      o_map_addr = w_rom_full[ROM_AW-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/cart_mbc1.sv
// ============================================================================
// Module  : cart_mbc1
// Brief   : MBC1 cartridge mapper; turns console strobes into memory requests.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cart_mbc1
  import gb_cart_pkg::*;
#(
  parameter int ROM_AW = 21,
  parameter int RAM_AW = 15
) (
  input  wire logic   clk,
  input  wire logic   reset_n,
  cart_mbc1_if.slave  bus
);

  logic              r_wr_d;
  logic              r_rd_d;
  logic [15:0]       r_addr_d;
  logic [0:0]        r_state;
  logic              r_pend_v;
  logic              r_pend_we;
  logic              r_pend_ram;
  logic [ROM_AW-1:0] r_pend_addr;
  logic [7:0]        r_pend_wdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_mem_ram;
  logic [ROM_AW-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic [7:0]        r_cart_do;

  logic [1:0]        w_rgn;
  logic              w_wr_evt;
  logic              w_rd_trig;
  logic              w_ram_off;
  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_new;
  logic              w_ram_en;
  logic [ROM_AW-1:0] w_map_addr;

  mbc1_regs #(
    .ROM_AW (ROM_AW),
    .RAM_AW (RAM_AW)
  ) u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_wr_evt   (w_wr_evt),
    .i_addr     (bus.cart_addr),
    .i_di       (bus.cart_di[4:0]),
    .o_ram_en   (w_ram_en),
    .o_map_addr (w_map_addr)
  );

  assign w_rgn     = region_of(bus.cart_addr);
  assign w_wr_evt  = bus.cart_wr && !r_wr_d;
  assign w_rd_trig = bus.cart_rd && (!r_rd_d || (bus.cart_addr != r_addr_d)) &&
                     (w_rgn != c_RGN_NONE);
  assign w_ram_off = (w_rgn == c_RGN_CRAM) && !w_ram_en;
  assign w_wr_req  = w_wr_evt && (w_rgn == c_RGN_CRAM) && w_ram_en;
  assign w_rd_req  = w_rd_trig && !w_ram_off && !w_wr_req;
  assign w_new     = w_wr_req || w_rd_req;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_d       <= 1'b0;
      r_rd_d       <= 1'b0;
      r_addr_d     <= 16'h0000;
      r_state      <= c_ST_IDLE;
      r_pend_v     <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_ram   <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= 8'h00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_ram    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_cart_do    <= 8'hFF;
    end else begin
      r_wr_d   <= bus.cart_wr;
      r_rd_d   <= bus.cart_rd;
      r_addr_d <= bus.cart_addr;

      // Disabled cart RAM reads float high on the real bus.
      if (w_rd_trig && w_ram_off)
        r_cart_do <= 8'hFF;
      else if ((r_state == c_ST_BUSY) && bus.mem_ack && !r_mem_we)
        r_cart_do <= bus.mem_rdata;

      case (r_state)
        c_ST_IDLE: begin
          if (w_new) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_wr_req;
            r_mem_ram   <= (w_rgn == c_RGN_CRAM);
            r_mem_addr  <= w_map_addr;
            r_mem_wdata <= bus.cart_di;
            r_state     <= c_ST_BUSY;
          end
        end
        c_ST_BUSY: begin
          if (bus.mem_ack) begin
            r_pend_v <= 1'b0;
            // A fresh trigger supersedes anything parked in the pending slot.
            if (w_new) begin
              r_mem_we    <= w_wr_req;
              r_mem_ram   <= (w_rgn == c_RGN_CRAM);
              r_mem_addr  <= w_map_addr;
              r_mem_wdata <= bus.cart_di;
            end else if (r_pend_v) begin
              r_mem_we    <= r_pend_we;
              r_mem_ram   <= r_pend_ram;
              r_mem_addr  <= r_pend_addr;
              r_mem_wdata <= r_pend_wdata;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= c_ST_IDLE;
            end
          end else if (w_new) begin
            r_pend_v     <= 1'b1;
            r_pend_we    <= w_wr_req;
            r_pend_ram   <= (w_rgn == c_RGN_CRAM);
            r_pend_addr  <= w_map_addr;
            r_pend_wdata <= bus.cart_di;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_ram   = r_mem_ram;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.cart_do   = r_cart_do;

endmodule

`default_nettype wire
